// File: rtl/can_mc_bus_bridge_if.sv
// Wrapper-side and register-bank-side signals of the CAN microcontroller bus bridge.
// The bridge takes the slave view; the wrapper/bank models take the master view.
interface can_mc_bus_bridge_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 31
);
  logic [DATA_W-1:0]   i_bus_data;
  logic [ADDR_W-1:0]   i_addr;
  logic                i_r_neg_w;
  logic                i_cs;
  logic [DATA_W-1:0]   o_reg_data;
  logic                o_ack;
  logic                o_error;
  logic                o_busy;
  logic [DATA_W-1:0]   i_reg_r_data;
  logic                i_reg_ack;
  logic                i_reg_error;
  logic [DATA_W-1:0]   o_reg_w_bus;
  logic [NUM_REGS-1:0] o_rs_vector;
  logic                o_r_neg_w;

  modport slave (
    input  i_bus_data, i_addr, i_r_neg_w, i_cs, i_reg_r_data, i_reg_ack, i_reg_error,
    output o_reg_data, o_ack, o_error, o_busy, o_reg_w_bus, o_rs_vector, o_r_neg_w
  );

  modport master (
    output i_bus_data, i_addr, i_r_neg_w, i_cs, i_reg_r_data, i_reg_ack, i_reg_error,
    input  o_reg_data, o_ack, o_error, o_busy, o_reg_w_bus, o_rs_vector, o_r_neg_w
  );
endinterface

// File: rtl/can_mc_bus_bridge.sv
// Single-transaction bridge from the wrapper chip-select strobe to a one-hot register select.
// Latency: ack 2 cycles after the cs edge minimum; no queueing, starts while busy are dropped.
module can_mc_bus_bridge #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 31,
  parameter int TIMEOUT  = 16
) (
  input  logic               i_sys_clk,
  input  logic               i_reset,
  can_mc_bus_bridge_if.slave bus
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic          cs_q;
  logic [TW-1:0] timer;
  logic          start;
  logic          addr_oor;

  assign start    = bus.i_cs & ~cs_q;
  assign addr_oor = (int'(bus.i_addr) >= NUM_REGS);

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state           <= IDLE;
      cs_q            <= 1'b1;
      timer           <= '0;
      bus.o_reg_data  <= '0;
      bus.o_ack       <= 1'b0;
      bus.o_error     <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_reg_w_bus <= '0;
      bus.o_rs_vector <= '0;
      bus.o_r_neg_w   <= 1'b0;
    end else begin
      cs_q            <= bus.i_cs;
      bus.o_ack       <= 1'b0;
      bus.o_error     <= 1'b0;
      bus.o_rs_vector <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            bus.o_r_neg_w   <= bus.i_r_neg_w;
            bus.o_reg_w_bus <= bus.i_bus_data;
            bus.o_busy      <= 1'b1;
            timer           <= '0;
            if (addr_oor) begin
              state       <= DONE;
              bus.o_ack   <= 1'b1;
              bus.o_error <= 1'b1;
            end else begin
              state           <= ISSUE;
              bus.o_rs_vector <= NUM_REGS'(1) << bus.i_addr;
            end
          end
        end
        // The ISSUE cycle counts toward the timeout, so WAIT starts with timer = 1.
        ISSUE, WAIT: begin
          if (bus.i_reg_ack) begin
            state       <= DONE;
            bus.o_ack   <= 1'b1;
            bus.o_error <= bus.i_reg_error;
            if (bus.o_r_neg_w && !bus.i_reg_error) begin
              bus.o_reg_data <= bus.i_reg_r_data;
            end
          end else if (state == WAIT && timer == TMAX) begin
            state       <= DONE;
            bus.o_ack   <= 1'b1;
            bus.o_error <= 1'b1;
          end else begin
            state <= WAIT;
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          state      <= IDLE;
          bus.o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_can_mc_bus_bridge.sv
// Randomised bench for can_mc_bus_bridge against a per-transaction outcome model.
module tb_can_mc_bus_bridge;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 6;
  localparam int NUM_REGS = 31;
  localparam int TIMEOUT  = 16;
  localparam int NEVER    = TIMEOUT + 2;
  localparam int WIN      = TIMEOUT + 4;

  logic i_sys_clk = 1'b0;
  logic i_reset;

  always #5 i_sys_clk = ~i_sys_clk;

  can_mc_bus_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) bus ();

  can_mc_bus_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_sys_clk(i_sys_clk),
    .i_reset  (i_reset),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] m_rdata;
  logic [DATA_W-1:0] m_wbus;
  logic              m_rnw;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One wrapper transaction; the bank acks k cycles after the select cycle (k >= TIMEOUT: too late).
  task automatic run_txn(input int addr, input bit rnw, input logic [DATA_W-1:0] wd,
                         input int k, input bit berr, input logic [DATA_W-1:0] rd,
                         input bit reedge_en);
    int          exp_ack_c, ack_c, acks, busy_n, rs_n, reedge;
    bit          in_range, exp_err, got_err;
    logic [63:0] rs_first, exp_rs;

    in_range = (addr < NUM_REGS);
    if (!in_range) begin
      exp_ack_c = 1;
      exp_err   = 1'b1;
    end else if (k < TIMEOUT) begin
      exp_ack_c = k + 2;
      exp_err   = berr;
      if (rnw && !berr) m_rdata = rd;
    end else begin
      exp_ack_c = TIMEOUT + 1;
      exp_err   = 1'b1;
    end
    m_rnw    = rnw;
    m_wbus   = wd;
    exp_rs   = in_range ? (64'(1) << addr) : 64'(0);
    reedge   = (reedge_en && exp_ack_c >= 2) ? int'($urandom_range(1, exp_ack_c - 1)) : 0;
    ack_c    = 0;
    acks     = 0;
    busy_n   = 0;
    rs_n     = 0;
    got_err  = 1'b0;
    rs_first = '0;

    @(posedge i_sys_clk); #1;
    bus.i_cs      = 1'b0;
    bus.i_reg_ack = 1'b0;
    @(posedge i_sys_clk); #1;
    bus.i_cs       = 1'b1;
    bus.i_addr     = addr[ADDR_W-1:0];
    bus.i_r_neg_w  = rnw;
    bus.i_bus_data = wd;

    for (int c = 1; c <= WIN; c++) begin
      @(posedge i_sys_clk); #1;
      bus.i_addr       = ADDR_W'($urandom);
      bus.i_bus_data   = $urandom;
      bus.i_r_neg_w    = 1'($urandom);
      bus.i_reg_ack    = (c == 1 + k);
      bus.i_reg_error  = berr;
      bus.i_reg_r_data = (c == 1 + k) ? rd : DATA_W'($urandom);
      if (reedge != 0) bus.i_cs = (c != reedge);
      @(negedge i_sys_clk);
      if (c == 1) rs_first = 64'(bus.o_rs_vector);
      if (bus.o_rs_vector != '0) rs_n++;
      if (bus.o_busy) busy_n++;
      if (bus.o_ack) begin
        acks++;
        ack_c   = c;
        got_err = bus.o_error;
      end
    end
    bus.i_reg_ack = 1'b0;

    chk("ack_count",   64'(acks),   64'(1));
    chk("ack_cycle",   64'(ack_c),  64'(exp_ack_c));
    chk("error",       64'(got_err), 64'(exp_err));
    chk("busy_cycles", 64'(busy_n), 64'(exp_ack_c));
    chk("rs_select",   rs_first,    exp_rs);
    chk("rs_pulses",   64'(rs_n),   64'(in_range));
    chk("reg_data",    64'(bus.o_reg_data),  64'(m_rdata));
    chk("r_neg_w",     64'(bus.o_r_neg_w),   64'(m_rnw));
    chk("reg_w_bus",   64'(bus.o_reg_w_bus), 64'(m_wbus));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 64'({bus.o_ack, bus.o_error, bus.o_busy, bus.o_r_neg_w,
                  |bus.o_rs_vector, |bus.o_reg_data, |bus.o_reg_w_bus}), 64'(0));
  endtask

  initial begin
    int acks, busy_n, addr, k;

    i_reset          = 1'b1;
    bus.i_cs         = 1'b0;
    bus.i_addr       = '0;
    bus.i_r_neg_w    = 1'b0;
    bus.i_bus_data   = '0;
    bus.i_reg_ack    = 1'b0;
    bus.i_reg_error  = 1'b0;
    bus.i_reg_r_data = '0;
    m_rdata = '0;
    m_wbus  = '0;
    m_rnw   = 1'b0;

    repeat (3) @(posedge i_sys_clk);
    @(negedge i_sys_clk);
    chk_all_zero("reset_outputs");
    i_reset = 1'b0;

    run_txn(5,  1'b1, 32'h0BAD_F00D, 0,     1'b0, 32'hDEAD_BEEF, 1'b0);
    run_txn(30, 1'b0, 32'h1234_5678, 3,     1'b0, 32'h5555_AAAA, 1'b0);
    run_txn(40, 1'b1, 32'hCAFE_0001, 0,     1'b0, 32'h1111_1111, 1'b0);
    run_txn(2,  1'b1, 32'h0000_0002, NEVER, 1'b0, 32'h2222_2222, 1'b0);
    run_txn(0,  1'b1, 32'h0,         TIMEOUT - 1, 1'b0, 32'h7777_0000, 1'b1);
    run_txn(30, 1'b1, 32'h0,         4,     1'b1, 32'h9999_9999, 1'b1);
    run_txn(31, 1'b0, 32'hFFFF_FFFF, 0,     1'b0, 32'h0,         1'b0);
    run_txn(63, 1'b1, 32'h0,         2,     1'b0, 32'h0,         1'b0);
    run_txn(12, 1'b1, 32'h0,         TIMEOUT, 1'b0, 32'h3333_3333, 1'b1);

    for (int t = 0; t < 40; t++) begin
      addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(NUM_REGS, 63))
                                         : int'($urandom_range(0, NUM_REGS - 1));
      k    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TIMEOUT, NEVER))
                                         : int'($urandom_range(0, TIMEOUT - 1));
      run_txn(addr, 1'($urandom), $urandom, k, ($urandom_range(0, 3) == 0),
              $urandom, 1'($urandom));
    end

    // Abort in WAIT with cs held high: nothing may restart until cs toggles.
    @(posedge i_sys_clk); #1;
    bus.i_cs      = 1'b0;
    bus.i_reg_ack = 1'b0;
    @(posedge i_sys_clk); #1;
    bus.i_cs      = 1'b1;
    bus.i_addr    = 6'd7;
    bus.i_r_neg_w = 1'b1;
    repeat (4) @(posedge i_sys_clk);
    #1 i_reset = 1'b1;
    @(posedge i_sys_clk);
    @(negedge i_sys_clk);
    chk_all_zero("reset_mid_txn");
    i_reset = 1'b0;
    m_rdata = '0;
    m_wbus  = '0;
    m_rnw   = 1'b0;
    acks   = 0;
    busy_n = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge i_sys_clk); #1;
      bus.i_reg_ack    = 1'($urandom);
      bus.i_reg_r_data = $urandom;
      @(negedge i_sys_clk);
      if (bus.o_ack) acks++;
      if (bus.o_busy) busy_n++;
    end
    bus.i_reg_ack = 1'b0;
    chk("post_reset_acks", 64'(acks),   64'(0));
    chk("post_reset_busy", 64'(busy_n), 64'(0));
    run_txn(9, 1'b1, 32'h0, 1, 1'b0, 32'hA5A5_5A5A, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/can_mc_bus_bridge.md
# can_mc_bus_bridge

Parametrised microcontroller-to-configuration-register bridge for the CAN controller. It replaces the free-running read/write channel pair with a single transaction FSM. Each chip-select strobe from the wrapper is latched and decoded into a one-cycle one-hot register select. The bridge then waits for the register bank's acknowledge, with timeout and out-of-range address detection, and returns one registered ack/error pulse with read data to the wrapper.

## Interface
Parameters:
- DATA_W, 32, bus and register data width
- ADDR_W, 6, address width
- NUM_REGS, 31, number of selectable registers; width of o_rs_vector (NUM_REGS ≤ 2^ADDR_W)
- TIMEOUT, 16, max cycles in ISSUE+WAIT without i_reg_ack before abort (≥2)

Ports:
- i_sys_clk  in  1  system clock; sole clock, all logic rising-edge
- i_reset  in  1  synchronous, active-high reset
- i_bus_data  in  DATA_W  write data from wrapper
- i_addr  in  ADDR_W  register address from wrapper
- i_r_neg_w  in  1  1 = read, 0 = write
- i_cs  in  1  chip select; a transaction starts on its rising edge
- o_reg_data  out  DATA_W  read data to wrapper; held until the next successful read
- o_ack  out  1  one-cycle transaction-complete pulse
- o_error  out  1  valid only with o_ack; 1 = failed transaction
- o_busy  out  1  high from ISSUE through DONE
- i_reg_r_data  in  DATA_W  register bank read data, valid with i_reg_ack
- i_reg_ack  in  1  register bank acknowledge
- i_reg_error  in  1  register bank error, valid with i_reg_ack
- o_reg_w_bus  out  DATA_W  latched write data to register bank
- o_rs_vector  out  NUM_REGS  one-hot register select, one-cycle pulse
- o_r_neg_w  out  1  latched direction to register bank

## Operation
- Reset, synchronous: state = IDLE. All outputs are 0 at the next edge. The cs history register is set to 1, so a cs held high through reset needs a low-then-high re-strobe.
- Start: start = i_cs & ~cs_q, where cs_q is i_cs registered every cycle in every state.
- IDLE, on start:
  - Latch i_addr, i_r_neg_w and i_bus_data.
  - If i_addr ≥ NUM_REGS, go to DONE with err = 1. No select pulse is issued.
  - Otherwise go to ISSUE.
- ISSUE (one cycle):
  - o_rs_vector[addr] = 1, all other bits 0.
  - o_r_neg_w = latched direction; o_reg_w_bus = latched data.
  - Timer = 0.
  - If i_reg_ack = 1, go to DONE. Otherwise go to WAIT.
- WAIT:
  - o_rs_vector = 0.
  - If i_reg_ack = 1, go to DONE with err = i_reg_error.
  - Else if timer == TIMEOUT−1, go to DONE with err = 1.
  - Else timer increments by 1.
- Ack handling: when i_reg_ack is taken in ISSUE, err = i_reg_error. On a read acked with i_reg_error = 0, i_reg_r_data is captured into o_reg_data.
- o_reg_data is not updated on writes or on failed reads; it holds its previous value.
- DONE (one cycle): o_ack = 1 and o_error = err, then IDLE.
- Starts during ISSUE/WAIT/DONE are dropped: no queueing, no error. To start another transaction the host must bring i_cs low, then high again after o_ack.
- i_reg_ack outside ISSUE/WAIT is ignored.
- Timer width is clog2(TIMEOUT). It never wraps; it saturates at TIMEOUT−1.

## Timing
- All outputs are registered.
- Edge n samples the cs rising edge. ISSUE runs in cycle n+1, with o_rs_vector asserted during n+1.
- Same-cycle ack: i_reg_ack in ISSUE gives o_ack in cycle n+2. This is the minimum latency.
- Ack k cycles after ISSUE (k < TIMEOUT): o_ack in cycle n+2+k.
- Timeout: o_ack/o_error in cycle n+1+TIMEOUT.
- Out-of-range address: o_ack/o_error in cycle n+1, with no select.
- o_busy is high for every cycle the FSM is in ISSUE, WAIT or DONE.
- o_r_neg_w and o_reg_w_bus hold their latched values until the next transaction.
- Reset asserted mid-transaction aborts it. No o_ack is produced, and o_rs_vector is 0 from the reset edge.

## Test plan
- Read, addr 5, bank acks in ISSUE with 0xDEADBEEF → o_rs_vector = 0x20 for 1 cycle; o_ack in cycle n+2; o_error = 0; o_reg_data = 0xDEADBEEF.
- Write, addr 30, data 0x1234_5678, ack 3 cycles after ISSUE → o_reg_w_bus = 0x12345678; o_r_neg_w = 0; o_ack in cycle n+5; o_reg_data unchanged.
- Read, addr 40 (≥ 31) → no o_rs_vector bit set; o_ack = o_error = 1 in cycle n+1.
- Read, addr 2, bank never acks (TIMEOUT = 16) → o_ack = o_error = 1 in cycle n+17; o_reg_data unchanged.
- i_cs held high 20 cycles, plus a second rising edge while busy → exactly one transaction and one o_ack.
- Reset asserted in WAIT; i_cs high throughout → next edge gives all outputs 0 and IDLE; no transaction until i_cs toggles low→high.
